pipe_register_div: RTL and testbench

//   Parametrised elastic pipeline register for the divider datapath. DEPTH

---
 rtl/pipe_register_div.sv | 89 ++++++++
 tb/tb_pipe_register_div.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_register_div.sv
// Elastic DEPTH-stage valid/ready pipeline register for the divider datapath.
// Stage 0 loads din or the init seed; bubbles collapse and the pipe supports flush.
module pipe_register_div #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       init_load,
    input  logic [WIDTH-1:0]           init,
    input  logic [WIDTH-1:0]           din,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             accept, pop;

    // A stage can take a new word if it is empty or anything downstream frees up.
    always_comb begin
        logic chain;
        rdy   = '0;
        chain = out_ready | ~v_q[DEPTH-1];
        rdy[DEPTH-1] = chain;
        for (int k = DEPTH-2; k >= 0; k--) begin
            chain  = chain | ~v_q[k];
            rdy[k] = chain;
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign accept    = in_valid & in_ready;
    assign pop       = v_q[DEPTH-1] & out_ready;
    assign out_valid = v_q[DEPTH-1];
    assign dout      = data_q[DEPTH-1];
    assign count     = count_q;

    always_comb begin
        v_d     = v_q;
        data_d  = data_q;
        count_d = count_q + CW'(accept) - CW'(pop);
        if (rdy[0]) begin
            v_d[0] = accept;
            if (accept) begin
                data_d[0] = init_load ? init : din;
            end
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
        // Flush wins over any same-cycle accept or pop.
        if (flush) begin
            v_d     = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_register_div.sv
// Bench for pipe_register_div: directed vector table plus randomized traffic
// checked against a queue-of-words model with per-word acceptance timestamps.
module tb_pipe_register_div;
    localparam int W = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, init_load, flush, out_valid, out_ready;
    logic [W-1:0] init, din, dout;
    logic [2:0]   count;

    pipe_register_div #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .init_load(init_load), .init(init), .din(din), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         iv, il;
        logic [W-1:0] init, din;
        logic         fl, ordy;
        logic         e_ir, e_ov;
        logic [W-1:0] e_dout;
        logic [2:0]   e_cnt;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        int           t;
    } word_t;

    word_t q[$];
    vec_t  tab[$];
    int    edges  = 0;
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t row(input bit iv, input bit il, input int ini, input int dn,
                                 input bit fl, input bit ordy, input bit ir, input bit ov,
                                 input int dv, input int cnt);
        vec_t v;
        v.iv = iv; v.il = il; v.init = W'(ini); v.din = W'(dn);
        v.fl = fl; v.ordy = ordy; v.e_ir = ir; v.e_ov = ov;
        v.e_dout = W'(dv); v.e_cnt = 3'(cnt);
        return v;
    endfunction

    // One clock cycle: drive at negedge, check mid-low phase, advance model at posedge.
    task automatic step(input bit use_tab, input vec_t v, output bit acc);
        bit           m_ir, m_ov, m_pop;
        logic [W-1:0] m_d;
        int           m_c;
        in_valid  = v.iv;  init_load = v.il; init = v.init; din = v.din;
        flush     = v.fl;  out_ready = v.ordy;
        #1;
        m_ir  = !v.fl && (v.ordy || q.size() < D);
        m_ov  = (q.size() > 0) && ((edges - q[0].t) >= D);
        m_d   = m_ov ? q[0].d : '0;
        m_c   = q.size();
        if (use_tab) begin
            chk("tab_in_ready", in_ready, v.e_ir);
            chk("tab_out_valid", out_valid, v.e_ov);
            chk("tab_count", count, v.e_cnt);
            if (v.e_ov) chk("tab_dout", dout, v.e_dout);
        end else begin
            chk("rnd_in_ready", in_ready, m_ir);
            chk("rnd_out_valid", out_valid, m_ov);
            chk("rnd_count", count, m_c);
            if (m_ov) chk("rnd_dout", dout, m_d);
        end
        acc   = v.iv && m_ir;
        m_pop = m_ov && v.ordy;
        @(posedge clk);
        if (v.fl) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (acc) q.push_back('{d: (v.il ? v.init : v.din), t: edges});
        end
        edges++;
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        bit   acc;
        int   k;
        rst = 1'b1; in_valid = 0; init_load = 0; init = '0; din = '0;
        flush = 0; out_ready = 0;

        // Reset clears without any clock edge (first posedge is at t=5).
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Backpressure: fill, stall, then drain 1..5.
        tab.push_back(row(1,0,0,1,0,0, 1,0,0,0));
        tab.push_back(row(1,0,0,2,0,0, 1,0,0,1));
        tab.push_back(row(1,0,0,3,0,0, 1,0,0,2));
        tab.push_back(row(1,0,0,4,0,0, 1,0,0,3));
        tab.push_back(row(1,0,0,5,0,0, 0,1,1,4));
        tab.push_back(row(1,0,0,5,0,1, 1,1,1,4));
        tab.push_back(row(0,0,0,0,0,1, 1,1,2,4));
        tab.push_back(row(0,0,0,0,0,1, 1,1,3,3));
        tab.push_back(row(0,0,0,0,0,1, 1,1,4,2));
        tab.push_back(row(0,0,0,0,0,1, 1,1,5,1));
        tab.push_back(row(0,0,0,0,0,1, 1,0,0,0));
        // Init seeding vs streaming data.
        tab.push_back(row(1,1,'h3FF,1,0,1, 1,0,0,0));
        tab.push_back(row(1,0,'h3FF,1,0,1, 1,0,0,1));
        tab.push_back(row(0,0,0,0,0,1, 1,0,0,2));
        tab.push_back(row(0,0,0,0,0,1, 1,0,0,2));
        tab.push_back(row(0,0,0,0,0,1, 1,1,'h3FF,2));
        tab.push_back(row(0,0,0,0,0,1, 1,1,1,1));
        tab.push_back(row(0,0,0,0,0,1, 1,0,0,0));
        // Flush with three words held and a same-cycle offer.
        tab.push_back(row(1,0,0,'h21,0,0, 1,0,0,0));
        tab.push_back(row(1,0,0,'h22,0,0, 1,0,0,1));
        tab.push_back(row(1,0,0,'h23,0,0, 1,0,0,2));
        tab.push_back(row(1,0,0,'h24,1,0, 0,0,0,3));
        tab.push_back(row(0,0,0,0,0,0, 1,0,0,0));
        for (int i = 0; i < 4; i++) tab.push_back(row(0,0,0,0,0,1, 1,0,0,0));
        // Back-to-back stream 1..8 at full throughput.
        for (int i = 1; i <= 8; i++)
            tab.push_back(row(1,0,0,i,0,1, 1, i >= 5, (i >= 5) ? i-4 : 0, (i > 4) ? 4 : i-1));
        for (int i = 5; i <= 8; i++)
            tab.push_back(row(0,0,0,0,0,1, 1,1,i,9-i));
        tab.push_back(row(0,0,0,0,0,1, 1,0,0,0));

        foreach (tab[i]) step(1'b1, tab[i], acc);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            v = row(($urandom % 4) != 0, ($urandom % 5) == 0, $urandom, $urandom,
                    ($urandom % 25) == 0, ($urandom % 3) != 0, 0, 0, 0, 0);
            step(1'b0, v, acc);
        end

        // Reset pulse in the middle of a clock phase while streaming.
        in_valid = 1; out_ready = 1; din = 'h3A;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_dout", dout, 0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();

        // Fresh stream 0x10.. after reset, random readiness.
        k = 0;
        for (int i = 0; i < 80; i++) begin
            v = row(($urandom % 3) != 0, 0, 0, 'h10 + k, 0, ($urandom % 2) != 0, 0, 0, 0, 0);
            step(1'b0, v, acc);
            if (acc) k++;
        end
        for (int i = 0; i < 8; i++) step(1'b0, row(0,0,0,0,0,1, 0,0,0,0), acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end
endmodule
